dividend_rebuild: RTL and testbench
===================================

DIVIDEND_REBUILD -- requirements
Module: dividend_rebuild

Interface
REQ-001 Parameter W, default 8: operand width in bits (two's complement); result width is 2W.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, synchronous and active-low.
REQ-004 start  input  1  request pulse; sampled only in IDLE.
REQ-005 Q  input  signed W  quotient operand.
REQ-006 B  input  signed W  divisor operand.
REQ-007 R  input  signed W  remainder operand.
REQ-008 A  output  signed 2W  registered reconstructed dividend, A = Q*B + R.
REQ-009 busy  output  1  high whenever state is not IDLE.
REQ-010 done  output  1  one-cycle pulse marking A (and rem_ok) as updated.
REQ-011 rem_ok  output  1  registered remainder-consistency flag (see Configuration).

Function
REQ-012 The FSM SHALL have states IDLE, MUL, ADD and DONE.
REQ-013 IDLE with start=1 SHALL latch Q, B and R, clear the accumulator and iteration counter, and go to MUL.
REQ-014 MUL SHALL run a sequential shift-add multiply of the latched Q and B, one partial product per cycle, for exactly W cycles, then go to ADD.
REQ-015 Multiply SHALL use operand magnitudes with sign correction so that Q=-2^(W-1) and B=-2^(W-1) give the exact product.
REQ-016 ADD SHALL add sign-extended R to the 2W-bit product in one cycle, then go to DONE.
REQ-017 DONE SHALL load A, assert done for exactly that cycle, and return to IDLE on the next edge.
REQ-018 Latency from the edge sampling start to the edge after which done=1 SHALL be W+2 cycles (10 for W=8).
REQ-019 A SHALL hold its value between done pulses.
REQ-020 start while busy=1 SHALL be ignored, with no queuing; the in-flight result SHALL be unaffected.
REQ-021 start asserted during the DONE cycle SHALL be ignored; a new request is accepted in IDLE on the next cycle.
REQ-022 Operand changes after the latch edge SHALL NOT affect the in-flight result.
REQ-023 The 2W-bit result SHALL never overflow for any W-bit Q, B, R, and arithmetic SHALL be exact two's complement.
REQ-024 B=0 SHALL produce A=R after the normal latency, with no special-case timing.

Reset
REQ-025 rst_n=0 at a rising edge SHALL force IDLE, A=0, done=0, busy=0, rem_ok=0, and clear the counter and accumulator.
REQ-026 Reset in MUL or ADD SHALL abort the operation with no done pulse.
REQ-027 The first start SHALL be accepted on the first edge with rst_n=1.

Configuration
REQ-028 Macro DIVIDEND_REBUILD_CHECK_EN SHALL control the remainder-consistency checker.
REQ-029 With the macro defined, rem_ok SHALL be loaded in DONE as 1 only if all of the following hold; otherwise 0:
  - B != 0;
  - |R| < |B|;
  - R = 0 or sign(R) = sign(A), per the truncating-division convention.
REQ-030 Without the macro, the checker logic SHALL be absent, and rem_ok SHALL be 1 in DONE and held thereafter (0 only after reset).

Verification
REQ-031 Q=3, B=7, R=2, start -> done after 10 cycles, A=23, rem_ok=1.
REQ-032 Q=-3, B=7, R=-2 -> A=-23, rem_ok=1; Q=-128, B=-128, R=0 -> A=16384; Q=-128, B=127, R=-128 -> A=-16384.
REQ-033 Q=5, B=3, R=4 -> A=19 and rem_ok=0 with the checker; rem_ok=1 without it. Q=4, B=0, R=9 -> A=9, and rem_ok=0 with the checker.
REQ-034 Start a request with Q=2, B=2, R=1 -> A=5. Pulse start with new operands at cycles 3 and 10 (the DONE cycle) -> both ignored, exactly one done. Start again at cycle 11 -> accepted.
REQ-035 Assert rst_n=0 at cycle 5 of MUL -> next cycle A=0, busy=0, no done. A fresh request after release completes correctly in 10 cycles.

Source files
------------

// File: rtl/dividend_rebuild.sv
// Reconstructs a dividend A = Q*B + R with a W-cycle shift-add multiply followed by a single add.
// Optional remainder-consistency checker enabled by defining DIVIDEND_REBUILD_CHECK_EN.
module dividend_rebuild #(
  parameter int W = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic signed [W-1:0]   Q,
  input  logic signed [W-1:0]   B,
  input  logic signed [W-1:0]   R,
  output logic signed [2*W-1:0] A,
  output logic                  busy,
  output logic                  done,
  output logic                  rem_ok
);

  localparam int CW = $clog2(W + 1);

  typedef enum logic [1:0] {
    IDLE,
    MUL,
    ADD,
    DONE
  } state_t;

  state_t state, state_nxt;

  logic [CW-1:0]          cnt;
  logic [2*W-1:0]         mcand;
  logic [2*W-1:0]         acc;
  logic [W-1:0]           mplier;
  logic                   neg;
  logic signed [W-1:0]    r_lat;
  logic [2*W-1:0]         prod;
  logic signed [2*W-1:0]  sum;
  logic                   rem_chk;

  // Magnitude as an unsigned W-bit value; -2^(W-1) maps to 2^(W-1) exactly.
  function automatic logic [W-1:0] mag(input logic signed [W-1:0] x);
    logic [W-1:0] m;
    m = x[W-1] ? W'(-x) : W'(x);
    return m;
  endfunction

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (start) state_nxt = MUL;
      MUL:  if (cnt == CW'(W - 1)) state_nxt = ADD;
      ADD:  state_nxt = DONE;
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  assign busy = (state != IDLE);
  assign done = (state == DONE);

  always_comb begin
    prod = neg ? (~acc + 1'b1) : acc;
    sum  = $signed(prod) + $signed({{W{r_lat[W-1]}}, r_lat});
  end

`ifdef DIVIDEND_REBUILD_CHECK_EN
  logic signed [W-1:0] b_lat;

  always_ff @(posedge clk) begin
    if (!rst_n)                       b_lat <= '0;
    else if (state == IDLE && start)  b_lat <= B;
  end

  // Truncating division: a nonzero remainder carries the dividend's sign.
  always_comb begin
    rem_chk = (b_lat != '0)
           && (mag(r_lat) < mag(b_lat))
           && ((r_lat == '0) || (r_lat[W-1] == sum[2*W-1]));
  end
`else
  assign rem_chk = 1'b1;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt    <= '0;
      mcand  <= '0;
      acc    <= '0;
      mplier <= '0;
      neg    <= 1'b0;
      r_lat  <= '0;
      A      <= '0;
      rem_ok <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            mcand  <= {{W{1'b0}}, mag(Q)};
            mplier <= mag(B);
            neg    <= Q[W-1] ^ B[W-1];
            r_lat  <= R;
            acc    <= '0;
            cnt    <= '0;
          end
        end
        MUL: begin
          if (mplier[0]) acc <= acc + mcand;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt + CW'(1);
        end
        ADD: begin
          // A and rem_ok are registered on the ADD->DONE edge so they are valid while done is high.
          A      <= sum;
          rem_ok <= rem_chk;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_dividend_rebuild.sv
// Scoreboard bench for dividend_rebuild: expected A/rem_ok queued at start, compared on done.
module tb_dividend_rebuild;

  localparam int W = 8;

  typedef struct {
    int a;
    int ok;
  } exp_t;

  logic                  clk;
  logic                  rst_n;
  logic                  start;
  logic signed [W-1:0]   Q, B, R;
  logic signed [2*W-1:0] A;
  logic                  busy, done, rem_ok;

  int   n_checks = 0;
  int   n_fail   = 0;
  int   done_cnt = 0;
  exp_t sb[$];

  dividend_rebuild #(.W(W)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .Q      (Q),
    .B      (B),
    .R      (R),
    .A      (A),
    .busy   (busy),
    .done   (done),
    .rem_ok (rem_ok)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) if (done) done_cnt++;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int model_ok(input int a, input int b, input int r);
`ifdef DIVIDEND_REBUILD_CHECK_EN
    int ar, ab;
    ar = (r < 0) ? -r : r;
    ab = (b < 0) ? -b : b;
    return int'((b != 0) && (ar < ab) && ((r == 0) || ((r < 0) == (a < 0))));
`else
    return 1;
`endif
  endfunction

  // Drives one request at the current negedge; optionally pulses extra starts at cycles 3 and 10.
  task automatic run_op(input int q, input int b, input int r, input bit inject);
    exp_t e;
    bit   seen;
    int   lat;
    int   d0;
    e.a  = q * b + r;
    e.ok = model_ok(e.a, b, r);
    sb.push_back(e);
    d0    = done_cnt;
    Q     = W'(q);
    B     = W'(b);
    R     = W'(r);
    start = 1'b1;
    seen  = 1'b0;
    lat   = 0;
    for (int unsigned cyc = 1; cyc <= 20 && !seen; cyc++) begin
      @(negedge clk);
      start = 1'b0;
      if (cyc == 2) check("busy_mid", int'(busy), 1);
      if (done) begin
        seen = 1'b1;
        lat  = int'(cyc);
      end
      if (inject && (cyc == 3 || cyc == 10)) begin
        Q     = W'($urandom_range(0, 255));
        B     = W'($urandom_range(1, 255));
        R     = W'($urandom_range(0, 255));
        start = 1'b1;
      end
    end
    if (!seen) begin
      check("done_timeout", 0, 1);
      void'(sb.pop_front());
    end else begin
      check("latency", lat, W + 2);
      if (sb.size() == 0) begin
        check("sb_empty", 0, 1);
      end else begin
        e = sb.pop_front();
        check("a_value", int'(A), e.a);
        check("rem_ok", int'(rem_ok), e.ok);
      end
      @(negedge clk);
      start = 1'b0;
      check("done_pulse", int'(done), 0);
      check("busy_idle", int'(busy), 0);
      check("a_hold", int'(A), e.a);
      check("done_count", done_cnt - d0, 1);
    end
  endtask

  task automatic reset_abort();
    int d0;
    Q     = W'(11);
    B     = W'(-9);
    R     = W'(3);
    start = 1'b1;
    for (int unsigned cyc = 1; cyc <= 5; cyc++) begin
      @(negedge clk);
      start = 1'b0;
    end
    rst_n = 1'b0;
    d0    = done_cnt;
    @(negedge clk);
    check("rst_a", int'(A), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_rem_ok", int'(rem_ok), 0);
    rst_n = 1'b1;
    repeat (12) @(negedge clk);
    check("abort_no_done", done_cnt - d0, 0);
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    Q     = '0;
    B     = '0;
    R     = '0;
    repeat (3) @(negedge clk);
    check("reset_a", int'(A), 0);
    check("reset_busy", int'(busy), 0);
    check("reset_done", int'(done), 0);
    check("reset_rem_ok", int'(rem_ok), 0);

    rst_n = 1'b1;
    run_op(3, 7, 2, 1'b0);
    run_op(-3, 7, -2, 1'b0);
    run_op(-128, -128, 0, 1'b0);
    run_op(-128, 127, -128, 1'b0);
    run_op(5, 3, 4, 1'b0);
    run_op(4, 0, 9, 1'b0);
    run_op(2, 2, 1, 1'b1);
    run_op(7, -5, 3, 1'b0);

    reset_abort();
    run_op(3, 7, 2, 1'b0);

    for (int unsigned i = 0; i < 8; i++) begin
      run_op(int'($urandom_range(0, 255)) - 128,
             int'($urandom_range(0, 255)) - 128,
             int'($urandom_range(0, 255)) - 128, 1'b0);
    end

    check("sb_drained", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL global_timeout: got timeout expected finish");
    $fatal(1);
  end

endmodule
